// File: rtl/boxhead_timer_master.sv
// boxhead_timer_master: hardware Avalon-MM master for the SoC interval timer.
// Programs period and mode, starts the timer, services each timeout with a
// one-cycle frame_tick, and reads counter snapshots on request.
// Bus outputs are registered from the next state, so each access is visible
// during the cycle the FSM occupies the corresponding state.
module boxhead_timer_master #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic              frame_tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [15:0]       m_writedata,
    input  logic [15:0]       m_readdata,
    input  logic              m_irq
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_STOP   = 4'd1;
    localparam logic [3:0] S_PL     = 4'd2;
    localparam logic [3:0] S_PH     = 4'd3;
    localparam logic [3:0] S_CLR0   = 4'd4;
    localparam logic [3:0] S_GO     = 4'd5;
    localparam logic [3:0] S_RUN    = 4'd6;
    localparam logic [3:0] S_ACK    = 4'd7;
    localparam logic [3:0] S_SETTLE = 4'd8;
    localparam logic [3:0] S_SW     = 4'd9;
    localparam logic [3:0] S_RL     = 4'd10;
    localparam logic [3:0] S_WL     = 4'd11;
    localparam logic [3:0] S_RH     = 4'd12;
    localparam logic [3:0] S_WH     = 4'd13;
    localparam logic [3:0] S_XSTOP  = 4'd14;

    localparam logic [15:0] CTRL_STOP = 16'h0008;
    localparam logic [15:0] CTRL_GO   = 16'h0005;
    localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

    logic [3:0]  state_r;
    logic [3:0]  next_s;
    logic [31:0] period_r;
    logic        cont_r;
    logic        ret_run_r;
    logic        ret_run_s;
    logic        snap_pend_r;
    logic        snap_pend_s;
    logic [15:0] snap_lo_r;
    logic        start_acc_s;

    // Bus beat for a state: {chipselect, write_n, address, writedata}.
    function automatic logic [20:0] bus_for(input logic [3:0] st,
                                            input logic [31:0] period,
                                            input logic cont);
        logic [20:0] b;
        case (st)
            S_STOP:  b = {1'b1, 1'b0, 3'd1, CTRL_STOP};
            S_PL:    b = {1'b1, 1'b0, 3'd2, period[15:0]};
            S_PH:    b = {1'b1, 1'b0, 3'd3, period[31:16]};
            S_CLR0:  b = {1'b1, 1'b0, 3'd0, 16'h0000};
            S_GO:    b = {1'b1, 1'b0, 3'd1, CTRL_GO | {14'd0, cont, 1'b0}};
            S_ACK:   b = {1'b1, 1'b0, 3'd0, 16'h0000};
            S_SW:    b = {1'b1, 1'b0, 3'd4, 16'h0000};
            S_RL:    b = {1'b1, 1'b1, 3'd4, 16'h0000};
            S_RH:    b = {1'b1, 1'b1, 3'd5, 16'h0000};
            S_XSTOP: b = {1'b1, 1'b0, 3'd1, CTRL_STOP};
            default: b = {1'b0, 1'b1, 3'd0, 16'h0000};
        endcase
        return b;
    endfunction

    // Timer considered running in RUN and in any detour that left from RUN.
    function automatic logic running_for(input logic [3:0] st, input logic ret_run);
        logic r;
        case (st)
            S_RUN, S_ACK, S_SETTLE:               r = 1'b1;
            S_SW, S_RL, S_WL, S_RH, S_WH, S_XSTOP: r = ret_run;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state selection; in RUN stop beats irq beats snapshot.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_stop) begin
                    next_s = S_XSTOP;
                end else if (snap_req) begin
                    next_s = S_SW;
                end else if (cfg_start) begin
                    next_s = S_STOP;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_STOP:   next_s = S_PL;
            S_PL:     next_s = S_PH;
            S_PH:     next_s = S_CLR0;
            S_CLR0:   next_s = S_GO;
            S_GO:     next_s = S_RUN;
            S_RUN: begin
                if (cfg_stop) begin
                    next_s = S_XSTOP;
                end else if (m_irq) begin
                    next_s = S_ACK;
                end else if (snap_req || snap_pend_r) begin
                    next_s = S_SW;
                end else begin
                    next_s = S_RUN;
                end
            end
            S_ACK:    next_s = S_SETTLE;
            S_SETTLE: next_s = cont_r ? S_RUN : S_IDLE;
            S_SW:     next_s = S_RL;
            S_RL:     next_s = S_WL;
            S_WL:     next_s = S_RH;
            S_RH:     next_s = S_WH;
            S_WH:     next_s = ret_run_r ? S_RUN : S_IDLE;
            S_XSTOP:  next_s = S_IDLE;
            default:  next_s = S_IDLE;
        endcase
    end

    // Return target, pending-snapshot bookkeeping and start acceptance.
    always_comb begin
        start_acc_s = (state_r == S_IDLE) && (next_s == S_STOP);
        if (state_r == S_RUN) begin
            ret_run_s = 1'b1;
        end else if (state_r == S_IDLE) begin
            ret_run_s = 1'b0;
        end else begin
            ret_run_s = ret_run_r;
        end
        if ((next_s == S_IDLE) || (next_s == S_SW)) begin
            snap_pend_s = 1'b0;
        end else if (snap_req && ((next_s == S_ACK) || (state_r == S_ACK) ||
                                  (state_r == S_SETTLE))) begin
            snap_pend_s = 1'b1;
        end else begin
            snap_pend_s = snap_pend_r;
        end
    end

    // FSM state and latched configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            period_r    <= 32'd0;
            cont_r      <= 1'b0;
            ret_run_r   <= 1'b0;
            snap_pend_r <= 1'b0;
            snap_lo_r   <= 16'h0000;
        end else begin
            state_r     <= next_s;
            ret_run_r   <= ret_run_s;
            snap_pend_r <= snap_pend_s;
            if (start_acc_s) begin
                period_r <= cfg_period;
                cont_r   <= cfg_continuous;
            end
            if (state_r == S_WL) begin
                snap_lo_r <= m_readdata;
            end
        end
    end

    // Registered outputs: bus beat, status flags, tick counter and snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 3'd0;
            m_writedata  <= 16'h0000;
            busy         <= 1'b0;
            running      <= 1'b0;
            frame_tick   <= 1'b0;
            tick_count   <= '0;
            snap_value   <= 32'd0;
            snap_valid   <= 1'b0;
        end else begin
            {m_chipselect, m_write_n, m_address, m_writedata} <= bus_for(next_s, period_r, cont_r);
            busy       <= !((next_s == S_IDLE) || (next_s == S_RUN));
            running    <= running_for(next_s, ret_run_s);
            frame_tick <= (next_s == S_ACK);
            if (start_acc_s) begin
                tick_count <= '0;
            end else if (next_s == S_ACK) begin
                tick_count <= tick_count + TICK_ONE;
            end
            snap_valid <= (state_r == S_WH);
            if (state_r == S_WH) begin
                snap_value <= {m_readdata, snap_lo_r};
            end
        end
    end

endmodule

// File: tb/tb_boxhead_timer_master.sv
// Testbench for boxhead_timer_master: table-driven start sequence, directed
// corner sequences and a randomized run against a sequence-queue model.
module tb_boxhead_timer_master;

    localparam int TAG_NONE = 0;
    localparam int TAG_TICK = 1;
    localparam int TAG_LO   = 2;
    localparam int TAG_HI   = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_continuous, cfg_stop, snap_req;
    logic [31:0] cfg_period;
    logic        busy, running, frame_tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [15:0] m_writedata, m_readdata;
    logic        m_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    boxhead_timer_master #(.TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .cfg_stop(cfg_stop),
        .snap_req(snap_req), .busy(busy), .running(running),
        .frame_tick(frame_tick), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid),
        .m_address(m_address), .m_chipselect(m_chipselect),
        .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_irq(m_irq)
    );

    // ---------------- reference model: queue of per-cycle bus beats ----------
    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] data;
        int          tag;
    } op_t;

    op_t         q[$];
    int          seq_kind;   // 0 none, 1 start, 2 tick, 3 snapshot, 4 stop
    bit          from_run;
    bit          rest_run;
    bit          pend;
    logic [31:0] m_period;
    bit          m_cont;
    logic [15:0] m_ticks;
    logic [15:0] m_lo;
    logic [31:0] m_snap;
    bit          m_snap_valid;
    bit          m_frame;

    logic [15:0] slave_lo, slave_hi;
    logic [19:0] acc_log[$];

    function automatic op_t mk(input logic cs, input logic wn, input logic [2:0] a,
                               input logic [15:0] d, input int tag);
        op_t o;
        o.cs = cs; o.wn = wn; o.addr = a; o.data = d; o.tag = tag;
        return o;
    endfunction

    task automatic model_reset();
        q.delete();
        seq_kind = 0; from_run = 0; rest_run = 0; pend = 0;
        m_ticks = 16'd0; m_snap = 32'd0; m_snap_valid = 0; m_frame = 0;
        m_lo = 16'd0; m_period = 32'd0; m_cont = 0;
    endtask

    task automatic push_snap(input bit fr);
        q.push_back(mk(1'b1, 1'b0, 3'd4, 16'h0000, TAG_NONE));
        q.push_back(mk(1'b1, 1'b1, 3'd4, 16'h0000, TAG_NONE));
        q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, TAG_LO));
        q.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0000, TAG_NONE));
        q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, TAG_HI));
        seq_kind = 3; from_run = fr; pend = 0;
    endtask

    // One clock edge of the model, given the inputs present before the edge.
    task automatic model_edge(input bit start, input bit stop, input bit snap,
                              input bit irq, input logic [31:0] per, input bit cont,
                              input logic [15:0] rd);
        op_t o;
        m_snap_valid = 0;
        if (q.size() > 0) begin
            o = q.pop_front();
            if (o.tag == TAG_LO) m_lo = rd;
            if (o.tag == TAG_HI) begin
                m_snap = {rd, m_lo};
                m_snap_valid = 1;
            end
            if (seq_kind == 2 && snap) pend = 1;
            if (q.size() == 0) begin
                seq_kind = 0;
                if (!rest_run) pend = 0;
            end
        end else if (rest_run) begin
            if (stop) begin
                q.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0008, TAG_NONE));
                rest_run = 0; pend = 0; seq_kind = 4; from_run = 1;
            end else if (irq) begin
                q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, TAG_TICK));
                q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, TAG_NONE));
                rest_run = m_cont; seq_kind = 2; from_run = 1;
                if (snap) pend = 1;
            end else if (snap || pend) begin
                push_snap(1'b1);
            end
        end else begin
            if (stop) begin
                q.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0008, TAG_NONE));
                seq_kind = 4; from_run = 0;
            end else if (snap) begin
                push_snap(1'b0);
            end else if (start) begin
                m_period = per; m_cont = cont; m_ticks = 16'd0;
                q.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0008, TAG_NONE));
                q.push_back(mk(1'b1, 1'b0, 3'd2, per[15:0], TAG_NONE));
                q.push_back(mk(1'b1, 1'b0, 3'd3, per[31:16], TAG_NONE));
                q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, TAG_NONE));
                q.push_back(mk(1'b1, 1'b0, 3'd1, cont ? 16'h0007 : 16'h0005, TAG_NONE));
                rest_run = 1; seq_kind = 1; from_run = 0;
            end
        end
        m_frame = (q.size() > 0) && (q[0].tag == TAG_TICK);
        if (m_frame) m_ticks = m_ticks + 16'd1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        op_t e;
        if (q.size() > 0) e = q[0];
        else e = mk(1'b0, 1'b1, 3'd0, 16'h0000, TAG_NONE);
        chk("cs", 32'(m_chipselect), 32'(e.cs));
        chk("write_n", 32'(m_write_n), 32'(e.wn));
        if (e.cs) chk("addr", 32'(m_address), 32'(e.addr));
        if (e.cs && !e.wn) chk("wdata", 32'(m_writedata), 32'(e.data));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("running", 32'(running), 32'((q.size() > 0) ? from_run : rest_run));
        chk("frame_tick", 32'(frame_tick), 32'(m_frame));
        chk("tick_count", 32'(tick_count), 32'(m_ticks));
        chk("snap_value", snap_value, m_snap);
        chk("snap_valid", 32'(snap_valid), 32'(m_snap_valid));
    endtask

    task automatic chk_reset_values();
        chk("rst_cs", 32'(m_chipselect), 32'd0);
        chk("rst_write_n", 32'(m_write_n), 32'd1);
        chk("rst_addr", 32'(m_address), 32'd0);
        chk("rst_wdata", 32'(m_writedata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_frame", 32'(frame_tick), 32'd0);
        chk("rst_ticks", 32'(tick_count), 32'd0);
        chk("rst_snap", snap_value, 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
    endtask

    // One clock: slave behaviour, model step, full comparison, pulses dropped.
    task automatic step();
        logic [15:0] rd_pre;
        logic        irq_pre, st_pre, sp_pre, sn_pre, ct_pre;
        logic [31:0] per_pre;
        logic        rd_fire, clr_irq;
        logic [2:0]  rd_addr;
        rd_pre = m_readdata; irq_pre = m_irq; st_pre = cfg_start; sp_pre = cfg_stop;
        sn_pre = snap_req; ct_pre = cfg_continuous; per_pre = cfg_period;
        rd_fire = m_chipselect && m_write_n;
        rd_addr = m_address;
        clr_irq = m_chipselect && !m_write_n && (m_address == 3'd0);
        @(posedge clk);
        #1;
        model_edge(st_pre, sp_pre, sn_pre, irq_pre, per_pre, ct_pre, rd_pre);
        if (clr_irq) m_irq = 1'b0;
        if (rd_fire) m_readdata = (rd_addr == 3'd4) ? slave_lo :
                                  (rd_addr == 3'd5) ? slave_hi : 16'h0000;
        else m_readdata = 16'($urandom);
        if (m_chipselect) acc_log.push_back({m_write_n, m_address, m_write_n ? 16'h0000 : m_writedata});
        compare_model();
        cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
    endtask

    // ---------------- start-sequence vector table ----------------
    typedef struct {
        logic        start;
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        run;
        logic        bsy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int fcnt;
        int vcnt;
        logic [15:0] t0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 3'd1, 16'h0008, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 3'd2, 16'hC34F, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 3'd1, 16'h0007, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0};

        reset_n = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
        cfg_period = 32'd0; cfg_continuous = 1'b0; m_readdata = 16'h0000; m_irq = 1'b0;
        slave_lo = 16'h0000; slave_hi = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Start sequence, continuous, period 49999.
        cfg_period = 32'd49999; cfg_continuous = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cfg_start = tbl[i].start;
            step();
            chk("tbl_cs", 32'(m_chipselect), 32'(tbl[i].cs));
            chk("tbl_write_n", 32'(m_write_n), 32'(tbl[i].wn));
            if (tbl[i].cs) begin
                chk("tbl_addr", 32'(m_address), 32'(tbl[i].addr));
                chk("tbl_wdata", 32'(m_writedata), 32'(tbl[i].data));
            end
            chk("tbl_running", 32'(running), 32'(tbl[i].run));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].bsy));
        end

        // Three serviced timeouts in continuous mode.
        for (int k = 0; k < 3; k++) begin
            m_irq = 1'b1;
            step();
            chk("ack_frame", 32'(frame_tick), 32'd1);
            chk("ack_write", 32'({m_chipselect, m_write_n, m_address}), 32'({1'b1, 1'b0, 3'd0}));
            step();
            chk("settle_frame", 32'(frame_tick), 32'd0);
            step();
        end
        chk("three_ticks", 32'(tick_count), 32'd3);
        chk("still_running", 32'(running), 32'd1);
        chk("not_busy", 32'(busy), 32'd0);

        // Snapshot from RUN.
        slave_lo = 16'h1234; slave_hi = 16'h0005;
        acc_log.delete();
        vcnt = 0;
        snap_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (snap_valid) vcnt++;
        end
        chk("snap_value", snap_value, 32'h0005_1234);
        chk("snap_valid_count", 32'(vcnt), 32'd1);
        chk("snap_acc_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() >= 3) begin
            chk("snap_acc0", 32'(acc_log[0]), 32'({1'b0, 3'd4, 16'h0000}));
            chk("snap_acc1", 32'(acc_log[1]), 32'({1'b1, 3'd4, 16'h0000}));
            chk("snap_acc2", 32'(acc_log[2]), 32'({1'b1, 3'd5, 16'h0000}));
        end

        // irq and snap_req together: ACK first, then snapshot.
        slave_lo = 16'hBEEF; slave_hi = 16'hCAFE;
        acc_log.delete();
        t0 = tick_count;
        fcnt = 0; vcnt = 0;
        m_irq = 1'b1; snap_req = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (frame_tick) fcnt++;
            if (snap_valid) vcnt++;
        end
        chk("both_ticks", 32'(tick_count - t0), 32'd1);
        chk("both_frames", 32'(fcnt), 32'd1);
        chk("both_valid", 32'(vcnt), 32'd1);
        chk("both_snap", snap_value, 32'hCAFE_BEEF);
        if (acc_log.size() >= 2) begin
            chk("both_first_ack", 32'(acc_log[0]), 32'({1'b0, 3'd0, 16'h0000}));
            chk("both_then_sw", 32'(acc_log[1]), 32'({1'b0, 3'd4, 16'h0000}));
        end else begin
            chk("both_acc_count", 32'(acc_log.size()), 32'd4);
        end

        // Stop, then one-shot start with period 0x0001_0000.
        cfg_stop = 1'b1;
        step();
        chk("stop_write", 32'({m_chipselect, m_write_n, m_address, m_writedata}),
            32'({1'b1, 1'b0, 3'd1, 16'h0008}));
        step();
        chk("stopped_running", 32'(running), 32'd0);
        acc_log.delete();
        cfg_period = 32'h0001_0000; cfg_continuous = 1'b0; cfg_start = 1'b1;
        repeat (6) step();
        chk("os_acc_count", 32'(acc_log.size()), 32'd5);
        if (acc_log.size() >= 5) begin
            chk("os_pl", 32'(acc_log[1]), 32'({1'b0, 3'd2, 16'h0000}));
            chk("os_ph", 32'(acc_log[2]), 32'({1'b0, 3'd3, 16'h0001}));
            chk("os_go", 32'(acc_log[4]), 32'({1'b0, 3'd1, 16'h0005}));
        end
        chk("os_running", 32'(running), 32'd1);
        m_irq = 1'b1;
        repeat (4) step();
        chk("os_ticks", 32'(tick_count), 32'd1);
        chk("os_idle_running", 32'(running), 32'd0);
        chk("os_idle_busy", 32'(busy), 32'd0);

        // Reset asserted during the PH write.
        cfg_period = 32'd49999; cfg_continuous = 1'b1; cfg_start = 1'b1;
        step();
        step();
        step();
        chk("ph_addr", 32'(m_address), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values();
        model_reset();
        m_irq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        acc_log.delete();
        repeat (8) step();
        chk("post_reset_quiet", 32'(acc_log.size()), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cfg_start = ($urandom_range(0, 19) == 0);
            cfg_stop = ($urandom_range(0, 79) == 0);
            snap_req = ($urandom_range(0, 14) == 0);
            cfg_period = $urandom;
            cfg_continuous = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) m_irq = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                slave_lo = 16'($urandom);
                slave_hi = 16'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
